// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - six-stage pipeline sequencer with LM/SM micro-op expansion
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   hdu_stall         : load-use stall request from hazard detection
//   exe_branch_taken  : taken branch/jump resolved in execute
//   mem_busy          : memory stage cannot complete this cycle
//   decode_is_lmsm    : decode holds an LM/SM instruction
//   decode_lmsm_mask  : register list of that instruction
//   *_en              : per-stage FIFO load enables
//   flush_fd/dr/re    : load a bubble into the F/D, D/R, R/E FIFOs
//   pc_wr             : PC register may update
//   lmsm_valid/reg_idx/offset/last : LM/SM micro-op issued from decode
module pipeline_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hdu_stall,
  input  logic                exe_branch_taken,
  input  logic                mem_busy,
  input  logic                decode_is_lmsm,
  input  logic [NUM_REGS-1:0] decode_lmsm_mask,
  output logic                fetch_en,
  output logic                decode_en,
  output logic                reg_read_en,
  output logic                execute_en,
  output logic                memory_access_en,
  output logic                write_back_en,
  output logic                flush_fd,
  output logic                flush_dr,
  output logic                flush_re,
  output logic                pc_wr,
  output logic                lmsm_valid,
  output logic [IDX_W-1:0]    lmsm_reg_idx,
  output logic [IDX_W-1:0]    lmsm_offset,
  output logic                lmsm_last
);

  typedef enum logic {RUN, LMSM} state_t;

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]    count_q, count_d;

  logic [NUM_REGS-1:0] src_mask;
  logic [NUM_REGS-1:0] src_rest;
  logic [IDX_W-1:0]    low_idx;
  logic                src_multi;

  // In LMSM the registered remainder drives issue and decode_is_lmsm is ignored.
  always_comb begin
    src_mask = '0;
    if (state_q == LMSM) begin
      src_mask = mask_q;
    end else if (decode_is_lmsm) begin
      src_mask = decode_lmsm_mask;
    end
  end

  // Descending scan so the last hit is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (src_mask[i]) low_idx = IDX_W'(i);
    end
  end

  // Clearing the lowest set bit; a non-zero remainder means more micro-ops follow.
  assign src_rest  = src_mask & (src_mask - NUM_REGS'(1));
  assign src_multi = (src_rest != '0);

  always_comb begin
    fetch_en         = 1'b1;
    decode_en        = 1'b1;
    reg_read_en      = 1'b1;
    execute_en       = 1'b1;
    memory_access_en = 1'b1;
    write_back_en    = 1'b1;
    flush_fd         = 1'b0;
    flush_dr         = 1'b0;
    flush_re         = 1'b0;
    pc_wr            = 1'b1;
    lmsm_valid       = 1'b0;
    lmsm_reg_idx     = '0;
    lmsm_offset      = '0;
    lmsm_last        = 1'b0;
    state_d          = state_q;
    mask_d           = mask_q;
    count_d          = count_q;

    if (rst) begin
      {fetch_en, decode_en, reg_read_en, execute_en, memory_access_en, write_back_en} = '0;
      {flush_fd, flush_dr, flush_re} = 3'b111;
      pc_wr   = 1'b0;
      state_d = RUN;
      mask_d  = '0;
      count_d = '0;
    end else if (mem_busy) begin
      {fetch_en, decode_en, reg_read_en, execute_en, memory_access_en, write_back_en} = '0;
      pc_wr = 1'b0;
    end else if (exe_branch_taken) begin
      {flush_fd, flush_dr, flush_re} = 3'b111;
      state_d = RUN;
      mask_d  = '0;
      count_d = '0;
    end else if (hdu_stall) begin
      // Hold fetch and PC, push a bubble behind decode; LM/SM progress is frozen.
      fetch_en = 1'b0;
      pc_wr    = 1'b0;
      flush_dr = 1'b1;
    end else if (src_mask != '0) begin
      lmsm_valid   = 1'b1;
      lmsm_reg_idx = low_idx;
      lmsm_offset  = (state_q == LMSM) ? count_q : '0;
      if (src_multi) begin
        fetch_en = 1'b0;
        pc_wr    = 1'b0;
        state_d  = LMSM;
        mask_d   = src_rest;
        count_d  = lmsm_offset + IDX_W'(1);
      end else begin
        lmsm_last = 1'b1;
        state_d   = RUN;
        mask_d    = '0;
        count_d   = '0;
      end
    end else begin
      state_d = RUN;
      mask_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    mask_q  <= mask_d;
    count_q <= count_d;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst, hdu_stall, exe_branch_taken, mem_busy, decode_is_lmsm;
  logic [7:0] decode_lmsm_mask;
  logic       fetch_en, decode_en, reg_read_en, execute_en, memory_access_en, write_back_en;
  logic       flush_fd, flush_dr, flush_re, pc_wr, lmsm_valid, lmsm_last;
  logic [2:0] lmsm_reg_idx, lmsm_offset;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NUM_REGS(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .hdu_stall(hdu_stall), .exe_branch_taken(exe_branch_taken),
    .mem_busy(mem_busy), .decode_is_lmsm(decode_is_lmsm), .decode_lmsm_mask(decode_lmsm_mask),
    .fetch_en(fetch_en), .decode_en(decode_en), .reg_read_en(reg_read_en),
    .execute_en(execute_en), .memory_access_en(memory_access_en), .write_back_en(write_back_en),
    .flush_fd(flush_fd), .flush_dr(flush_dr), .flush_re(flush_re), .pc_wr(pc_wr),
    .lmsm_valid(lmsm_valid), .lmsm_reg_idx(lmsm_reg_idx), .lmsm_offset(lmsm_offset),
    .lmsm_last(lmsm_last)
  );

  // {en[5:0] fetch..wb, flush[2:0] fd/dr/re, pc_wr, valid, idx[2:0], offset[2:0], last}
  localparam logic [17:0] RESET  = {6'b000000, 3'b111, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
  localparam logic [17:0] NORM   = {6'b111111, 3'b000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0};
  localparam logic [17:0] STALL  = {6'b011111, 3'b010, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
  localparam logic [17:0] BRANCH = {6'b111111, 3'b111, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0};
  localparam logic [17:0] BUSY   = {6'b000000, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};

  function automatic logic [17:0] issue(input logic [2:0] idx, input logic [2:0] off, input logic last);
    if (last) return {6'b111111, 3'b000, 1'b1, 1'b1, idx, off, 1'b1};
    return {6'b011111, 3'b000, 1'b0, 1'b1, idx, off, 1'b0};
  endfunction

  logic [17:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic step(input logic r, input logic s, input logic b, input logic m,
                      input logic l, input logic [7:0] mk, input logic [17:0] e, input string nm);
    rst = r; hdu_stall = s; exe_branch_taken = b; mem_busy = m;
    decode_is_lmsm = l; decode_lmsm_mask = mk;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] act, e;
      string       nm;
      act = {fetch_en, decode_en, reg_read_en, execute_en, memory_access_en, write_back_en,
             flush_fd, flush_dr, flush_re, pc_wr, lmsm_valid, lmsm_reg_idx, lmsm_offset, lmsm_last};
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %b expected %b", nm, act, e);
    end
  end

  initial begin
    rst = 1'b1; hdu_stall = 1'b0; exe_branch_taken = 1'b0; mem_busy = 1'b0;
    decode_is_lmsm = 1'b0; decode_lmsm_mask = 8'h00;
    @(posedge clk); #1;

    step(1, 0, 0, 0, 0, 8'h00, RESET,  "reset_c1");
    step(1, 0, 0, 0, 0, 8'h00, RESET,  "reset_c2");
    step(0, 0, 0, 0, 0, 8'h00, NORM,   "after_reset");
    step(0, 1, 0, 0, 0, 8'h00, STALL,  "hdu_stall");
    step(0, 0, 0, 0, 0, 8'h00, NORM,   "after_stall");
    step(0, 1, 1, 0, 0, 8'h00, BRANCH, "branch_over_stall");
    step(0, 1, 1, 1, 0, 8'h00, BUSY,   "busy_over_branch");
    step(0, 0, 0, 0, 0, 8'h00, NORM,   "after_busy");

    // LM 1010_0100: decode_is_lmsm left high to show it is ignored in LMSM
    step(0, 0, 0, 0, 1, 8'hA4, issue(3'd2, 3'd0, 1'b0), "lm_a4_1");
    step(0, 0, 0, 0, 1, 8'hA4, issue(3'd5, 3'd1, 1'b0), "lm_a4_2");
    step(0, 0, 0, 0, 1, 8'hA4, issue(3'd7, 3'd2, 1'b1), "lm_a4_3");
    step(0, 0, 0, 0, 0, 8'h00, NORM,   "after_a4");

    // 8'hFF with a stall in cycle 3 and memory busy in cycle 5
    step(0, 0, 0, 0, 1, 8'hFF, issue(3'd0, 3'd0, 1'b0), "ff_c1");
    step(0, 0, 0, 0, 1, 8'hFF, issue(3'd1, 3'd1, 1'b0), "ff_c2");
    step(0, 1, 0, 0, 1, 8'hFF, STALL,                   "ff_c3_stall");
    step(0, 0, 0, 0, 1, 8'hFF, issue(3'd2, 3'd2, 1'b0), "ff_c4");
    step(0, 0, 0, 1, 1, 8'hFF, BUSY,                    "ff_c5_busy");
    step(0, 0, 0, 0, 1, 8'hFF, issue(3'd3, 3'd3, 1'b0), "ff_c6");
    step(0, 0, 0, 0, 1, 8'hFF, issue(3'd4, 3'd4, 1'b0), "ff_c7");
    step(0, 0, 0, 0, 1, 8'hFF, issue(3'd5, 3'd5, 1'b0), "ff_c8");
    step(0, 0, 0, 0, 1, 8'hFF, issue(3'd6, 3'd6, 1'b0), "ff_c9");
    step(0, 0, 0, 0, 0, 8'h00, issue(3'd7, 3'd7, 1'b1), "ff_c10");
    step(0, 0, 0, 0, 0, 8'h00, NORM,   "after_ff");

    // 8'h0F aborted by a branch in issue cycle 2
    step(0, 0, 0, 0, 1, 8'h0F, issue(3'd0, 3'd0, 1'b0), "0f_c1");
    step(0, 0, 1, 0, 1, 8'h0F, BRANCH, "0f_branch");
    step(0, 0, 0, 0, 0, 8'h00, NORM,   "0f_after_abort");

    step(0, 0, 0, 0, 1, 8'h00, NORM,   "empty_mask");
    step(0, 0, 0, 0, 1, 8'h80, issue(3'd7, 3'd0, 1'b1), "single_bit7");
    step(0, 0, 0, 0, 0, 8'h00, NORM,   "after_single");

    // Reset mid-expansion aborts it
    step(0, 0, 0, 0, 1, 8'h03, issue(3'd0, 3'd0, 1'b0), "03_c1");
    step(1, 0, 0, 0, 0, 8'h00, RESET,  "03_reset");
    step(0, 0, 0, 0, 0, 8'h00, NORM,   "03_after_reset");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
